// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle control FSM with memory handshake, illegal-opcode trap and retire counter
module unidad_control_multiciclo #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W = 16,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               PCSrc,
  output logic [1:0]         BrType,
  output logic               Illegal,
  output logic [CNT_W-1:0]   RetireCount
);
  localparam logic [5:0] opR = 6'b000000, opAddi = 6'b001000, opOri = 6'b001101, opAndi = 6'b001100;
  localparam logic [5:0] opSlti = 6'b001010, opLw = 6'b100011, opSw = 6'b101011;
  localparam logic [5:0] opBeq = 6'b000100, opBne = 6'b000101, opBgtz = 6'b000111;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB, ALU_WB, BRANCH, HALT
  } stateT;
  stateT state, nextState;
  logic [5:0] OpReg;
  logic [CNT_W-1:0] count;
  logic [2:0] aluOp;
  logic retire, isR, isI, isMem, isBr;
  assign isR = OpCode == opR;
  assign isI = OpCode == opAddi || OpCode == opOri || OpCode == opAndi || OpCode == opSlti;
  assign isMem = OpCode == opLw || OpCode == opSw;
  assign isBr = OpCode == opBeq || OpCode == opBne || OpCode == opBgtz;
  assign ALUOp = ALUOP_W'(aluOp);
  assign RetireCount = reset ? '0 : count;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      OpReg <= '0;
      count <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) OpReg <= OpCode;
      if (retire) count <= count + 1'b1;
    end
  end
  always_comb begin
    nextState = state;
    retire = 1'b0;
    {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA} = '0;
    ALUSrcB = 2'b00;
    aluOp = 3'd0;
    PCSrc = 1'b0;
    BrType = 2'b00;
    Illegal = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        nextState = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b10;
        nextState = isR ? EXEC_R : isI ? EXEC_I : isMem ? MEM_ADDR : isBr ? BRANCH :
                    (TRAP_ILLEGAL != 0) ? HALT : FETCH;
        retire = !(isR || isI || isMem || isBr) && TRAP_ILLEGAL == 0;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        aluOp = 3'd2;
        nextState = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (OpReg == opOri || OpReg == opAndi) ? 2'b11 : 2'b10;
        aluOp = OpReg == opOri ? 3'd3 : OpReg == opAndi ? 3'd4 : OpReg == opSlti ? 3'd5 : 3'd0;
        nextState = ALU_WB;
      end
      ALU_WB: begin
        RegWrite = 1'b1;
        RegDst = OpReg == opR;
        retire = 1'b1;
        nextState = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nextState = OpReg == opLw ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        IorD = 1'b1;
        MemRead = 1'b1;
        nextState = MemReady ? MEM_WB : MEM_READ;
      end
      MEM_WRITE: begin
        IorD = 1'b1;
        MemWrite = 1'b1;
        retire = MemReady;
        nextState = MemReady ? FETCH : MEM_WRITE;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        retire = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        aluOp = 3'd1;
        PCWriteCond = 1'b1;
        PCSrc = 1'b1;
        BrType = OpReg == opBne ? 2'b01 : OpReg == opBgtz ? 2'b10 : 2'b00;
        retire = 1'b1;
        nextState = FETCH;
      end
      HALT: Illegal = 1'b1;
      default: nextState = FETCH;
    endcase
    // reset forces every output low combinationally, not just from the next edge
    if (reset) {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, aluOp, PCSrc, BrType, Illegal} = '0;
  end
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: table vectors, corner sequences and random stimulus against a phase-based model
module tb_unidad_control_multiciclo;
  logic clk = 0, reset = 1, MemReady = 0;
  logic [5:0] OpCode = '0;
  logic [19:0] outv[3];
  logic [15:0] cntv[3];
  int vecs = 0, miss = 0;
  always #5 clk = ~clk;

  localparam logic [19:0] ILL = 20'h00001, BT01 = 20'h00002, BT10 = 20'h00004, PCSRC = 20'h00008;
  localparam logic [19:0] OPSUB = 20'h00010, OPFUN = 20'h00020, OPOR = 20'h00030, OPAND = 20'h00040;
  localparam logic [19:0] OPSLT = 20'h00050, B4 = 20'h00080, BIMM = 20'h00100, BZ = 20'h00180;
  localparam logic [19:0] SA = 20'h00200, RW = 20'h00400, RD = 20'h00800, MTR = 20'h01000;
  localparam logic [19:0] MWR = 20'h02000, MRD = 20'h04000, IRW = 20'h08000, IORD = 20'h10000;
  localparam logic [19:0] PCWC = 20'h20000, PCW = 20'h40000;
  localparam logic [19:0] F1 = PCW | IRW | MRD | B4, F0 = MRD | B4;

  // instance 0 default, 1 illegal-as-NOP, 2 narrow counter and wide ALUOp
  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int CW = g == 2 ? 4 : 16;
    localparam int AW = g == 2 ? 5 : 3;
    logic pcw, pcwc, iord, irw, mrd, mwr, mtr, rd, rw, sa, pcs, ill;
    logic [1:0] sb, bt;
    logic [AW-1:0] aop;
    logic [CW-1:0] rc;
    logic [7:0] aopx;
    unidad_control_multiciclo #(.ALUOP_W(AW), .CNT_W(CW), .TRAP_ILLEGAL(g == 1 ? 0 : 1)) dut (
      .clk(clk), .reset(reset), .OpCode(OpCode), .MemReady(MemReady),
      .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .IRWrite(irw), .MemRead(mrd), .MemWrite(mwr),
      .MemToReg(mtr), .RegDst(rd), .RegWrite(rw), .ALUSrcA(sa), .ALUSrcB(sb), .ALUOp(aop),
      .PCSrc(pcs), .BrType(bt), .Illegal(ill), .RetireCount(rc)
    );
    assign aopx = 8'(aop);
    assign outv[g] = {|aopx[7:3], pcw, pcwc, iord, irw, mrd, mwr, mtr, rd, rw, sa, sb, aopx[2:0], pcs, bt, ill};
    assign cntv[g] = 16'(rc);
  end

  // model: instruction class + phase index within that instruction's cycle list
  int ph[3] = '{default: 0};
  logic [5:0] mop[3] = '{default: 6'd0};
  bit hlt[3] = '{default: 1'b0};
  int cm[3] = '{default: 0};

  function automatic int cls(logic [5:0] o);
    case (o)
      6'd0: return 0;
      6'd8, 6'd13, 6'd12, 6'd10: return 1;
      6'd35: return 2;
      6'd43: return 3;
      6'd4, 6'd5, 6'd7: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int len(int c);
    return c == 2 ? 5 : c == 4 ? 3 : c == 5 ? 2 : 4;
  endfunction

  function automatic logic [19:0] expv(int p, logic [5:0] o, bit h, bit r, bit mr);
    int c = cls(o);
    if (r) return 20'h0;
    if (h) return ILL;
    if (p == 0) return F0 | (mr ? (PCW | IRW) : 20'h0);
    if (p == 1) return BIMM;
    if (p == 2) begin
      if (c == 0) return SA | OPFUN;
      if (c == 1) return SA | ((o == 13 || o == 12) ? BZ : BIMM) |
                         (o == 13 ? OPOR : o == 12 ? OPAND : o == 10 ? OPSLT : 20'h0);
      if (c == 2 || c == 3) return SA | BIMM;
      if (c == 4) return SA | OPSUB | PCWC | PCSRC | (o == 5 ? BT01 : o == 7 ? BT10 : 20'h0);
    end
    if (p == 3) begin
      if (c == 0) return RW | RD;
      if (c == 1) return RW;
      if (c == 2) return IORD | MRD;
      if (c == 3) return IORD | MWR;
    end
    if (p == 4) return RW | MTR;
    return 20'h0;
  endfunction

  function automatic void step(int k, bit r, logic [5:0] o, bit mr);
    int c = cls(mop[k]);
    int msk = k == 2 ? 15 : 65535;
    if (r) begin
      ph[k] = 0; mop[k] = 0; hlt[k] = 0; cm[k] = 0;
      return;
    end
    if (hlt[k]) return;
    if ((ph[k] == 0 || (ph[k] == 3 && (c == 2 || c == 3))) && !mr) return;
    if (ph[k] == 1) begin
      mop[k] = o;
      if (cls(o) != 5) ph[k] = 2;
      else if (k != 1) hlt[k] = 1;
      else begin ph[k] = 0; cm[k] = (cm[k] + 1) & msk; end
    end else if (ph[k] == len(c) - 1) begin
      ph[k] = 0;
      cm[k] = (cm[k] + 1) & msk;
    end else ph[k]++;
  endfunction

  task automatic cyc(bit r, logic [5:0] o, bit mr, bit useT, logic [19:0] e, int c, string nm);
    reset = r; OpCode = o; MemReady = mr;
    #2;
    if (useT) begin
      vecs++;
      if (outv[0] !== e || cntv[0] !== 16'(c)) begin
        miss++;
        $display("FAIL %s: out=%h cnt=%0d expected out=%h cnt=%0d", nm, outv[0], cntv[0], e, c);
      end
    end
    for (int k = 0; k < 3; k++) begin
      logic [19:0] me;
      logic [15:0] mc;
      me = expv(ph[k], mop[k], hlt[k], r, mr);
      mc = r ? 16'd0 : 16'(cm[k]);
      vecs++;
      if (outv[k] !== me || cntv[k] !== mc) begin
        miss++;
        $display("FAIL model_%s inst%0d: out=%h cnt=%0d expected out=%h cnt=%0d", nm, k, outv[k], cntv[k], me, mc);
      end
    end
    for (int k = 0; k < 3; k++) step(k, r, o, mr);
    @(posedge clk);
    #1;
  endtask

  typedef struct {bit r; logic [5:0] op; bit mr; logic [19:0] e; int c;} vecT;
  vecT tbl[$];
  function automatic void add(bit r, logic [5:0] op, bit mr, logic [19:0] e, int c);
    vecT v;
    v.r = r; v.op = op; v.mr = mr; v.e = e; v.c = c;
    tbl.push_back(v);
  endfunction

  logic [5:0] pool[10] = '{6'd0, 6'd8, 6'd13, 6'd12, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5, 6'd7};

  initial begin
    add(1, 6'd0, 1, 20'h0, 0);
    add(0, 6'd0, 1, F1, 0); add(0, 6'd0, 1, BIMM, 0); add(0, 6'd0, 1, SA | OPFUN, 0); add(0, 6'd0, 1, RW | RD, 0);
    add(0, 6'd0, 0, F0, 1); add(0, 6'd0, 1, F1, 1); add(0, 6'd35, 1, BIMM, 1); add(0, 6'd0, 0, SA | BIMM, 1);
    add(0, 6'd0, 0, IORD | MRD, 1); add(0, 6'd0, 0, IORD | MRD, 1); add(0, 6'd0, 0, IORD | MRD, 1);
    add(0, 6'd0, 1, IORD | MRD, 1); add(0, 6'd0, 0, RW | MTR, 1);
    add(0, 6'd0, 1, F1, 2); add(0, 6'd13, 1, BIMM, 2); add(0, 6'd0, 1, SA | BZ | OPOR, 2); add(0, 6'd0, 1, RW, 2);
    add(0, 6'd0, 1, F1, 3); add(0, 6'd10, 1, BIMM, 3); add(0, 6'd0, 1, SA | BIMM | OPSLT, 3); add(0, 6'd0, 1, RW, 3);
    add(0, 6'd0, 1, F1, 4); add(0, 6'd5, 1, BIMM, 4); add(0, 6'd0, 1, SA | OPSUB | PCWC | PCSRC | BT01, 4);
    add(0, 6'd0, 1, F1, 5); add(0, 6'd7, 1, BIMM, 5); add(0, 6'd0, 1, SA | OPSUB | PCWC | PCSRC | BT10, 5);
    add(0, 6'd0, 1, F1, 6); add(0, 6'd43, 1, BIMM, 6); add(0, 6'd0, 1, SA | BIMM, 6); add(0, 6'd0, 1, IORD | MWR, 6);
    add(0, 6'd0, 1, F1, 7); add(0, 6'd63, 1, BIMM, 7); add(0, 6'd0, 1, ILL, 7); add(0, 6'd8, 0, ILL, 7);
    add(1, 6'd0, 1, 20'h0, 0); add(0, 6'd0, 1, F1, 0);
    @(posedge clk);
    #1;
    foreach (tbl[i]) cyc(tbl[i].r, tbl[i].op, tbl[i].mr, 1, tbl[i].e, tbl[i].c, $sformatf("vec%0d", i));
    cyc(0, 6'd63, 1, 1, BIMM, 0, "halt_dec");
    for (int i = 0; i < 10; i++) cyc(0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1, ILL, 0, "halt_hold");
    cyc(1, 6'd0, 1, 1, 20'h0, 0, "halt_reset");
    cyc(0, 6'd0, 1, 1, F1, 0, "halt_fetch");
    cyc(0, 6'd63, 1, 1, BIMM, 0, "nop_dec");
    cyc(1, 6'd0, 1, 0, 20'h0, 0, "wrap_reset");
    for (int i = 0; i < 16; i++) begin
      cyc(0, 6'd0, 1, 0, 20'h0, 0, "sw_f");
      cyc(0, 6'd43, 1, 0, 20'h0, 0, "sw_d");
      cyc(0, 6'd0, 1, 0, 20'h0, 0, "sw_a");
      cyc(0, 6'd0, 1, 1, IORD | MWR, i, "sw_w");
    end
    vecs++;
    if (cntv[2] !== 16'd0 || cntv[0] !== 16'd16) begin
      miss++;
      $display("FAIL wrap: narrow=%0d wide=%0d expected narrow=0 wide=16", cntv[2], cntv[0]);
    end
    cyc(0, 6'd0, 1, 1, F1, 16, "rst_f");
    cyc(0, 6'd43, 1, 1, BIMM, 16, "rst_d");
    cyc(0, 6'd0, 1, 1, SA | BIMM, 16, "rst_a");
    cyc(0, 6'd0, 0, 1, IORD | MWR, 16, "rst_w");
    cyc(1, 6'd0, 1, 1, 20'h0, 0, "rst_in_write");
    cyc(0, 6'd0, 0, 1, F0, 0, "rst_after");
    for (int i = 0; i < 3000; i++) begin
      bit r;
      logic [5:0] o;
      int sel;
      r = $urandom_range(0, 99) < 2 || (hlt[0] && $urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 12);
      o = sel < 10 ? pool[sel] : 6'($urandom_range(0, 63));
      cyc(r, o, $urandom_range(0, 3) != 0, 0, 20'h0, 0, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
